// File: rtl/match_event_logger.sv
// match_event_logger: timestamps each cycle where the detector's match pulse z is high.
// Timestamps go into a small first-word-fall-through FIFO that the host drains over valid/ready.
// The block also keeps a saturating match count and a sticky drop flag.
module match_event_logger #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       z,
    input  logic                       clr,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [TS_W-1:0]            ev_ts,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       drop_flag
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drop_q;

    logic full;
    logic pop;
    logic push;
    logic drop;

    // Handshake decode; a full FIFO still accepts a push when a pop frees the head slot.
    always_comb begin
        full = (level_q == FULL_LEVEL);
        pop  = (level_q != '0) && ev_ready;
        push = z && (!full || pop);
        drop = z && full && !pop;
    end

    // Free-running timestamp, pointers, occupancy, counter and drop flag; clr leaves ts alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (clr) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                level_q <= '0;
                cnt_q   <= '0;
                drop_q  <= 1'b0;
            end else begin
                if (push) begin
                    wptr_q <= wptr_q + PW'(1);
                end
                if (pop) begin
                    rptr_q <= rptr_q + PW'(1);
                end
                if (push && !pop) begin
                    level_q <= level_q + LW'(1);
                end else if (pop && !push) begin
                    level_q <= level_q - LW'(1);
                end
                if (z && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (drop) begin
                    drop_q <= 1'b1;
                end
            end
        end
    end

    // Entry storage; cleared on reset so the head reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (!clr && push) begin
            mem_q[wptr_q] <= ts_q;
        end
    end

    assign ev_valid  = (level_q != '0);
    assign ev_ts     = mem_q[rptr_q];
    assign level     = level_q;
    assign match_cnt = cnt_q;
    assign drop_flag = drop_q;

endmodule

// File: tb/tb_match_event_logger.sv
// Bench for match_event_logger: a default instance plus a narrow one (TS_W=4, CNT_W=2).
// Expected timestamps are queued when z is driven and compared as entries are popped.
module tb_match_event_logger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        z, clr, ev_ready;
    logic        ev_valid;
    logic [15:0] ev_ts;
    logic [2:0]  level;
    logic [15:0] match_cnt;
    logic        drop_flag;

    logic        zw, clrw, ev_readyw;
    logic        ev_valid_w;
    logic [3:0]  ev_ts_w;
    logic [2:0]  level_w;
    logic [1:0]  match_cnt_w;
    logic        drop_flag_w;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  expw_q[$];
    logic [15:0] tb_ts;
    logic [15:0] e16;
    logic [3:0]  e4;

    match_event_logger #(.TS_W(16), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .z(z), .clr(clr), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_ts(ev_ts), .level(level), .match_cnt(match_cnt), .drop_flag(drop_flag)
    );

    match_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .z(zw), .clr(clrw), .ev_valid(ev_valid_w),
        .ev_ready(ev_readyw), .ev_ts(ev_ts_w), .level(level_w), .match_cnt(match_cnt_w),
        .drop_flag(drop_flag_w)
    );

    always #5 clk = ~clk;

    // Independent cycle-count model of the DUT timestamp.
    always @(posedge clk) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; z = 1'b0; clr = 1'b0; ev_ready = 1'b0;
        zw = 1'b0; clrw = 1'b0; ev_readyw = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        expw_q.delete();
    endtask

    task automatic wait_ts(input logic [15:0] t);
        int n = 0;
        while (tb_ts != t && n < 300) begin
            tick();
            n++;
        end
        if (tb_ts != t) begin
            checks++; errors++;
            $display("FAIL wait_ts got %0d exp %0d", tb_ts, t);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; z = 1'b1; zw = 1'b1; clr = 1'b0; clrw = 1'b0;
        ev_ready = 1'b0; ev_readyw = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        checks++;
        if ({ev_valid, ev_ts, level, match_cnt, drop_flag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %0h exp 0", {ev_valid, ev_ts, level, match_cnt, drop_flag});
        end
        checks++;
        if ({ev_valid_w, ev_ts_w, level_w, match_cnt_w, drop_flag_w} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_w got %0h exp 0",
                     {ev_valid_w, ev_ts_w, level_w, match_cnt_w, drop_flag_w});
        end
        // Release with z held: the first three timestamps must be 0, 1, 2.
        rst_n = 1'b1; zw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'(i));
            tick();
        end
        z = 1'b0;
        checks++;
        if (level !== 3'd3 || match_cnt !== 16'd3) begin
            errors++;
            $display("FAIL reset_ts_level got %0d/%0d exp 3/3", level, match_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            e16 = exp_q.pop_front();
            checks++;
            if (ev_valid !== 1'b1 || ev_ts !== e16) begin
                errors++;
                $display("FAIL reset_ts_seq got %0d (v=%0b) exp %0d", ev_ts, ev_valid, e16);
            end
            ev_ready = 1'b1;
            tick();
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        wait_ts(16'd5);
        z = 1'b1;
        exp_q.push_back(tb_ts);
        tick();
        z = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_ts !== 16'd5 || level !== 3'd1 || match_cnt !== 16'd1) begin
                errors++;
                $display("FAIL single_hold got v=%0b ts=%0d lvl=%0d cnt=%0d exp v=1 ts=5 lvl=1 cnt=1",
                         ev_valid, ev_ts, level, match_cnt);
            end
            tick();
        end
        e16 = exp_q.pop_front();
        checks++;
        if (ev_ts !== e16) begin
            errors++;
            $display("FAIL single_pop_ts got %0d exp %0d", ev_ts, e16);
        end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++;
        if (ev_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL single_empty got v=%0b lvl=%0d exp v=0 lvl=0", ev_valid, level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        wait_ts(16'd10);
        for (int i = 0; i < 5; i++) begin
            z = 1'b1;
            if (i < 4) exp_q.push_back(tb_ts);
            if (i == 4) begin
                checks++;
                if (drop_flag !== 1'b0 || level !== 3'd4) begin
                    errors++;
                    $display("FAIL ovf_before_drop got drop=%0b lvl=%0d exp drop=0 lvl=4",
                             drop_flag, level);
                end
            end
            tick();
        end
        z = 1'b0;
        checks++;
        if (level !== 3'd4 || match_cnt !== 16'd5 || drop_flag !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state got lvl=%0d cnt=%0d drop=%0b exp lvl=4 cnt=5 drop=1",
                     level, match_cnt, drop_flag);
        end
        for (int i = 0; i < 4; i++) begin
            e16 = exp_q.pop_front();
            checks++;
            if (ev_valid !== 1'b1 || ev_ts !== e16) begin
                errors++;
                $display("FAIL ovf_drain got %0d (v=%0b) exp %0d", ev_ts, ev_valid, e16);
            end
            ev_ready = 1'b1;
            tick();
        end
        ev_ready = 1'b0;
        checks++;
        if (level !== 3'd0 || ev_valid !== 1'b0 || drop_flag !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after got lvl=%0d v=%0b drop=%0b exp 0/0/1", level, ev_valid, drop_flag);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        wait_ts(16'd20);
        for (int i = 0; i < 4; i++) begin
            z = 1'b1;
            exp_q.push_back(tb_ts);
            tick();
        end
        z = 1'b0;
        wait_ts(16'd30);
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL fpp_full got %0d exp 4", level);
        end
        z = 1'b1;
        ev_ready = 1'b1;
        e16 = exp_q.pop_front();
        checks++;
        if (ev_ts !== e16) begin
            errors++;
            $display("FAIL fpp_head got %0d exp %0d", ev_ts, e16);
        end
        exp_q.push_back(tb_ts);
        tick();
        z = 1'b0;
        ev_ready = 1'b0;
        checks++;
        if (level !== 3'd4 || drop_flag !== 1'b0 || match_cnt !== 16'd5) begin
            errors++;
            $display("FAIL fpp_state got lvl=%0d drop=%0b cnt=%0d exp lvl=4 drop=0 cnt=5",
                     level, drop_flag, match_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            e16 = exp_q.pop_front();
            checks++;
            if (ev_valid !== 1'b1 || ev_ts !== e16) begin
                errors++;
                $display("FAIL fpp_drain got %0d (v=%0b) exp %0d", ev_ts, ev_valid, e16);
            end
            ev_ready = 1'b1;
            tick();
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_reset();
        repeat (3) tick();
        z = 1'b1;
        repeat (2) tick();
        z = 1'b0;
        checks++;
        if (level !== 3'd2 || match_cnt !== 16'd2) begin
            errors++;
            $display("FAIL clr_pre got lvl=%0d cnt=%0d exp 2/2", level, match_cnt);
        end
        clr = 1'b1;
        z = 1'b1;
        tick();
        clr = 1'b0;
        z = 1'b0;
        checks++;
        if (level !== 3'd0 || ev_valid !== 1'b0 || match_cnt !== 16'd0 || drop_flag !== 1'b0) begin
            errors++;
            $display("FAIL clr_state got lvl=%0d v=%0b cnt=%0d drop=%0b exp all 0",
                     level, ev_valid, match_cnt, drop_flag);
        end
        repeat (2) tick();
        checks++;
        if (level !== 3'd0 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_store got lvl=%0d v=%0b exp 0/0", level, ev_valid);
        end
        z = 1'b1;
        exp_q.push_back(tb_ts);
        tick();
        z = 1'b0;
        e16 = exp_q.pop_front();
        checks++;
        if (ev_valid !== 1'b1 || ev_ts !== e16 || level !== 3'd1 || match_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clr_repush got ts=%0d v=%0b lvl=%0d cnt=%0d exp ts=%0d v=1 lvl=1 cnt=1",
                     ev_ts, ev_valid, level, match_cnt, e16);
        end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    task automatic test_wrap_sat();
        do_reset();
        wait_ts(16'd15);
        for (int i = 0; i < 5; i++) begin
            zw = 1'b1;
            if (i < 4) expw_q.push_back(tb_ts[3:0]);
            tick();
        end
        zw = 1'b0;
        checks++;
        if (match_cnt_w !== 2'd3 || level_w !== 3'd4 || drop_flag_w !== 1'b1) begin
            errors++;
            $display("FAIL wrap_state got cnt=%0d lvl=%0d drop=%0b exp cnt=3 lvl=4 drop=1",
                     match_cnt_w, level_w, drop_flag_w);
        end
        for (int i = 0; i < 4; i++) begin
            e4 = expw_q.pop_front();
            checks++;
            if (ev_valid_w !== 1'b1 || ev_ts_w !== e4) begin
                errors++;
                $display("FAIL wrap_drain got %0d (v=%0b) exp %0d", ev_ts_w, ev_valid_w, e4);
            end
            ev_readyw = 1'b1;
            tick();
        end
        ev_readyw = 1'b0;
        repeat (3) tick();
        checks++;
        if (match_cnt_w !== 2'd3 || level_w !== 3'd0) begin
            errors++;
            $display("FAIL sat_hold got cnt=%0d lvl=%0d exp cnt=3 lvl=0", match_cnt_w, level_w);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            z = 1'b1;
            ev_ready = 1'b1;
            if (i > 0) begin
                e16 = exp_q.pop_front();
                checks++;
                if (ev_valid !== 1'b1 || ev_ts !== e16 || level !== 3'd1) begin
                    errors++;
                    $display("FAIL b2b got ts=%0d v=%0b lvl=%0d exp ts=%0d v=1 lvl=1",
                             ev_ts, ev_valid, level, e16);
                end
            end
            exp_q.push_back(tb_ts);
            tick();
        end
        z = 1'b0;
        e16 = exp_q.pop_front();
        checks++;
        if (ev_ts !== e16 || match_cnt !== 16'd8) begin
            errors++;
            $display("FAIL b2b_last got ts=%0d cnt=%0d exp ts=%0d cnt=8", ev_ts, match_cnt, e16);
        end
        tick();
        ev_ready = 1'b0;
        checks++;
        if (level !== 3'd0 || ev_valid !== 1'b0 || drop_flag !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got lvl=%0d v=%0b drop=%0b exp 0/0/0", level, ev_valid, drop_flag);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_wrap_sat();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Timestamped logger for the serial pattern detector's registered match pulse `z`. It sits directly downstream of the detector and samples `z` on every clock. For each match it pushes a free-running cycle timestamp into a small first-word-fall-through FIFO, which the host drains over a valid/ready interface. It also keeps a saturating match count and a sticky drop flag.

## Interface
Parameters:
- `TS_W`, default 16: timestamp and cycle counter width.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥2.
- `CNT_W`, default 16: match counter width.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `z`  in  1: match pulse from the detector. One bit is sampled per clock, and each high cycle is one match.
- `clr`  in  1: synchronous soft clear.
- `ev_valid`  out  1: FIFO non-empty.
- `ev_ready`  in  1: host accepts the head entry.
- `ev_ts`  out  TS_W: head entry timestamp. Valid only while `ev_valid`=1.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `match_cnt`  out  CNT_W: total matches since reset or clr, saturating.
- `drop_flag`  out  1: sticky. Set when a match is lost because the FIFO was full.

## Operation
- **Cycle counter `ts`:**
  - Increments by 1 every clock.
  - Wraps from 2^TS_W−1 to 0.
  - Not affected by `clr`.
- **Push:**
  - Occurs when `z`=1 in a cycle and the FIFO accepts; the cycle's current `ts` value is written.
  - FIFO accepts when `level`<DEPTH, or when `level`=DEPTH and a pop occurs in the same cycle.
- **Pop:** occurs when `ev_valid` && `ev_ready`. Popping with `ev_valid`=0 is ignored.
- **Simultaneous push and pop:** `level` is unchanged and order is preserved. This applies at any level, including full. At `level`=0 no pop is possible, so only the push occurs.
- **Drop:** when `z`=1, `level`=DEPTH and no pop, the entry is discarded and `drop_flag` is set to 1. Existing entries are untouched.
- **`match_cnt`:**
  - Increments on every `z`=1 cycle, whether the entry was stored or dropped.
  - Saturates at 2^CNT_W−1; it never wraps.
- **FIFO organisation:**
  - Read and write pointers, each $clog2(DEPTH) bits, wrapping naturally.
  - Full/empty are derived from `level`.
  - `ev_ts` is the register at the read pointer (FWFT); it is stable while `ev_valid`=1 and no pop occurs.
- **`clr`=1:**
  - Empties the FIFO: `level`=0 and pointers return to 0.
  - Clears `match_cnt` and `drop_flag`.
  - Takes priority over a push, pop or count in the same cycle; a `z` in that cycle is discarded and not counted.
- **`rst_n`=0:**
  - Clears everything at the next edge: `ts`=0, `level`=0, `ev_valid`=0, `ev_ts`=0, `match_cnt`=0, `drop_flag`=0.
  - Overrides `clr` and any in-flight events. Mid-operation reset discards all stored entries.

## Timing
- Reset values: every output is 0. `ts`=0 in the first cycle after `rst_n` returns high.
- Push latency: `z`=1 in cycle n with `ts`=T gives, in cycle n+1:
  - `ev_valid`=1 and `ev_ts`=T, if the FIFO was empty;
  - `level` and `match_cnt` updated.
- Pop: a handshake in cycle n advances the head in cycle n+1. If it popped the last entry, `ev_valid`=0 in cycle n+1.
- Back-to-back: one push and one pop are sustained per cycle indefinitely, with no bubbles.
- `drop_flag` and `clr` effects are visible the cycle after the triggering edge.
- No combinational path from `z`, `clr` or `ev_ready` to any output; all outputs are registered or decoded from registers.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles with `z`=1 → all outputs 0. After release, the internal `ts` sequence is 0, 1, 2, …
2. **Single match:** `z`=1 at `ts`=5 with `ev_ready`=0 → next cycle `ev_valid`=1, `ev_ts`=5, `level`=1, `match_cnt`=1. Values hold stable for 4 cycles. Then `ev_ready`=1 for one cycle → next cycle `ev_valid`=0, `level`=0.
3. **Overflow (DEPTH=4):** `z`=1 at `ts`=10..14 with `ev_ready`=0 →
   - `level`=4 and `match_cnt`=5;
   - `drop_flag`=1;
   - draining yields 10, 11, 12, 13.
4. **Full push+pop:** with the FIFO full of 20, 21, 22, 23, `z`=1 at `ts`=30 and `ev_ready`=1 → `level` stays 4, `drop_flag` stays 0, and the drain order is 21, 22, 23, 30.
5. **Clear priority:** with `level`=2 and `match_cnt`=2, assert `clr`=1 together with `z`=1 → next cycle `level`=0, `ev_valid`=0, `match_cnt`=0, `drop_flag`=0, and no entry is stored.
6. **Wrap and saturation (TS_W=4, CNT_W=2):**
   - `z`=1 at `ts`=15, then at `ts`=0 → entries 15, 0.
   - 5 matches total → `match_cnt`=3, held.
